// File: rtl/regfile_mp_sb_if.sv
// Bus bundle for regfile_mp_sb: read ports, write port, reserve port and status.
//   ready_o   : file usable (clear sequence finished)
//   rd_addr_i : NREAD packed read addresses, port p at [p*AW +: AW]
//   rd_data_o : NREAD packed read data, port p at [p*WIDTH +: WIDTH]
//   rd_pend_o : per-port pending flag of the addressed entry
//   we_i / wr_addr_i / wr_data_i : write port (a write also retires the pending flag)
//   rsv_i / rsv_addr_i           : reserve port (marks an entry pending)
//   err_o     : sticky, a reserve hit an entry that was already pending
// master drives addresses/commands; slave is the register file.
interface regfile_mp_sb_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NREAD = 2
);
  localparam int AW = $clog2(DEPTH);

  logic                   ready_o;
  logic [NREAD*AW-1:0]    rd_addr_i;
  logic [NREAD*WIDTH-1:0] rd_data_o;
  logic [NREAD-1:0]       rd_pend_o;
  logic                   we_i;
  logic [AW-1:0]          wr_addr_i;
  logic [WIDTH-1:0]       wr_data_i;
  logic                   rsv_i;
  logic [AW-1:0]          rsv_addr_i;
  logic                   err_o;

  modport master (
    input  ready_o, rd_data_o, rd_pend_o, err_o,
    output rd_addr_i, we_i, wr_addr_i, wr_data_i, rsv_i, rsv_addr_i
  );

  modport slave (
    output ready_o, rd_data_o, rd_pend_o, err_o,
    input  rd_addr_i, we_i, wr_addr_i, wr_data_i, rsv_i, rsv_addr_i
  );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with a per-entry pending scoreboard, a hardware
// clear sequencer that zeroes every entry after reset, and optional forwarding of
// same-cycle write data to the read ports.
// Ports:
//   core_clock_i : clock, all state updates on the rising edge
//   core_reset_i : synchronous active-high reset, restarts the clear sequence
//   bus          : regfile_mp_sb_if slave (read/write/reserve ports, ready, error)
module regfile_mp_sb #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic            core_clock_i,
  input  logic            core_reset_i,
  regfile_mp_sb_if.slave  bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int NSLOT = 1 << AW;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t            state_reg, state_next;
  logic [AW-1:0]     clr_idx_reg, clr_idx_next;
  logic [DEPTH-1:0]  pend_reg, pend_next;
  logic              err_reg, err_next;

  logic [WIDTH-1:0]  rf_mem [DEPTH];
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;

  logic              ready;
  logic              wr_fire;
  logic              rsv_fire;

  // Addresses that really hold state: beyond DEPTH (non power-of-2 depth) and the
  // hard-wired zero entry are treated identically -- commands dropped, reads 0.
  logic [NSLOT-1:0]  slot_ok;
  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
    assign slot_ok[gi] = (gi < DEPTH) && !((ZERO_REG != 0) && (gi == 0));
  end

  assign ready    = (state_reg == ST_READY);
  assign wr_fire  = ready && bus.we_i  && slot_ok[bus.wr_addr_i];
  assign rsv_fire = ready && bus.rsv_i && slot_ok[bus.rsv_addr_i];

  always_ff @(posedge core_clock_i) begin
    if (core_reset_i) begin
      state_reg   <= ST_CLEAR;
      clr_idx_reg <= '0;
      pend_reg    <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      clr_idx_reg <= clr_idx_next;
      pend_reg    <= pend_next;
      err_reg     <= err_next;
    end
  end

  // Storage has no reset; the clear sequencer shares the single write port.
  always_ff @(posedge core_clock_i) begin
    if (mem_we) begin
      rf_mem[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_idx_next = clr_idx_reg;
    pend_next    = pend_reg;
    err_next     = err_reg;
    mem_we       = 1'b0;
    mem_waddr    = bus.wr_addr_i;
    mem_wdata    = bus.wr_data_i;

    case (state_reg)
      ST_CLEAR: begin
        mem_we    = !core_reset_i;
        mem_waddr = clr_idx_reg;
        mem_wdata = '0;
        if (clr_idx_reg == LAST_IDX) begin
          state_next = ST_READY;
        end else begin
          clr_idx_next = clr_idx_reg + 1'b1;
        end
      end
      ST_READY: begin
        mem_we = wr_fire;
        if (wr_fire) begin
          pend_next[bus.wr_addr_i] = 1'b0;
        end
        // Reserve is applied after the write so a same-address pair ends pending.
        if (rsv_fire) begin
          pend_next[bus.rsv_addr_i] = 1'b1;
          if (pend_reg[bus.rsv_addr_i] &&
              !(wr_fire && (bus.wr_addr_i == bus.rsv_addr_i))) begin
            err_next = 1'b1;
          end
        end
      end
      default: state_next = ST_CLEAR;
    endcase
  end

  logic [NREAD*WIDTH-1:0] rd_data_all;
  logic [NREAD-1:0]       rd_pend_all;

  for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
    logic             pend;
    logic             wr_hit;
    logic             rsv_hit;

    assign addr    = bus.rd_addr_i[gi*AW +: AW];
    assign wr_hit  = (BYPASS != 0) && wr_fire && (bus.wr_addr_i == addr);
    assign rsv_hit = rsv_fire && (bus.rsv_addr_i == addr);

    always_comb begin
      data = '0;
      pend = 1'b0;
      if (ready && slot_ok[addr]) begin
        data = rf_mem[addr];
        pend = pend_reg[addr];
        // A forwarded write retires the producer, unless a new reservation to the
        // same entry lands in the same cycle; then the stored flag is shown.
        if (wr_hit) begin
          data = bus.wr_data_i;
          pend = rsv_hit ? pend_reg[addr] : 1'b0;
        end
      end
    end

    assign rd_data_all[gi*WIDTH +: WIDTH] = data;
    assign rd_pend_all[gi]                = pend;
  end

  assign bus.ready_o   = ready;
  assign bus.err_o     = err_reg;
  assign bus.rd_data_o = rd_data_all;
  assign bus.rd_pend_o = rd_pend_all;
endmodule
